// File: rtl/demux1to4_stream_router_if.sv
// Stream bundle for the 1:4 router: one producer side, four consumer channels.
// Ports: in_valid/in_ready/in_sel/in_data/rr_mode in, out_valid/out_ready/out_data/out_count/last_sel out.
interface demux1to4_stream_router_if #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 8
);
  logic               in_valid;
  logic               in_ready;
  logic [1:0]         in_sel;
  logic [WIDTH-1:0]   in_data;
  logic               rr_mode;
  logic [3:0]         out_valid;
  logic [3:0]         out_ready;
  logic [4*WIDTH-1:0] out_data;
  logic [4*CNT_W-1:0] out_count;
  logic [1:0]         last_sel;

  modport master (
    output in_valid,
    input  in_ready,
    output in_sel,
    output in_data,
    output rr_mode,
    input  out_valid,
    output out_ready,
    input  out_data,
    input  out_count,
    input  last_sel
  );

  modport slave (
    input  in_valid,
    output in_ready,
    input  in_sel,
    input  in_data,
    input  rr_mode,
    output out_valid,
    input  out_ready,
    output out_data,
    output out_count,
    output last_sel
  );
endinterface

// File: rtl/demux1to4_stream_router.sv
// 1:4 stream router: steers one valid/ready stream into four one-entry channels.
// Ports: clk, rst (async high), bus (slave modport of demux1to4_stream_router_if).
module demux1to4_stream_router #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 8
) (
  input logic                     clk,
  input logic                     rst,
  demux1to4_stream_router_if.slave bus
);

  logic [1:0]         w_tgt;
  logic [3:0]         w_tgt_oh;
  logic               w_in_ready;
  logic               w_acc;
  logic [3:0]         w_load;
  logic [3:0]         w_drain;
  logic [4*WIDTH-1:0] w_out_data;
  logic [4*CNT_W-1:0] w_out_count;

  logic [3:0]         r_valid;
  logic [WIDTH-1:0]   r_data [4];
  logic [CNT_W-1:0]   r_cnt  [4];
  logic [1:0]         r_last;
  logic [1:0]         r_rr_ptr;

  assign w_tgt = bus.rr_mode ? r_rr_ptr : bus.in_sel;

  always_comb begin
    w_tgt_oh = 4'b0000;
    unique case (w_tgt)
      2'd0: w_tgt_oh = 4'b0001;
      2'd1: w_tgt_oh = 4'b0010;
      2'd2: w_tgt_oh = 4'b0100;
      2'd3: w_tgt_oh = 4'b1000;
    endcase
  end

  // A full target may still accept if it drains this same cycle.
  assign w_in_ready = ~r_valid[w_tgt] | bus.out_ready[w_tgt];
  assign w_acc      = bus.in_valid & w_in_ready;
  assign w_load     = w_tgt_oh & {4{w_acc}};
  assign w_drain    = r_valid & bus.out_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_valid  <= '0;
      r_last   <= '0;
      r_rr_ptr <= '0;
      for (int k = 0; k < 4; k++) begin
        r_data[k] <= '0;
        r_cnt[k]  <= '0;
      end
    end else begin
      for (int k = 0; k < 4; k++) begin
        if (w_load[k]) begin
          r_valid[k] <= 1'b1;
          r_data[k]  <= bus.in_data;
          r_cnt[k]   <= r_cnt[k] + CNT_W'(1);
        end else if (w_drain[k]) begin
          r_valid[k] <= 1'b0;
        end
      end
      if (w_acc) begin
        r_last <= w_tgt;
        // Pointer only moves on an accept, so a stall never skips a channel.
        if (bus.rr_mode)
          r_rr_ptr <= r_rr_ptr + 2'd1;
      end
    end
  end

  always_comb begin
    w_out_data  = '0;
    w_out_count = '0;
    for (int k = 0; k < 4; k++) begin
      w_out_data[k*WIDTH +: WIDTH]  = r_data[k];
      w_out_count[k*CNT_W +: CNT_W] = r_cnt[k];
    end
  end

  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = r_valid;
  assign bus.out_data  = w_out_data;
  assign bus.out_count = w_out_count;
  assign bus.last_sel  = r_last;

endmodule

// File: tb/tb_demux1to4_stream_router.sv
// Bench for demux1to4_stream_router: directed cases plus random traffic.
// Ports: none; drives the router through its interface.
module tb_demux1to4_stream_router;

  localparam int W = 4;
  localparam int C = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  demux1to4_stream_router_if #(.WIDTH(W), .CNT_W(C)) bus ();

  demux1to4_stream_router #(.WIDTH(W), .CNT_W(C)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int n_chk = 0;
  int n_err = 0;

  // Reference: each channel is a slot that is empty or holds one word.
  bit       m_full [4];
  int       m_word [4];
  int       m_cnt  [4];
  int       m_last;
  int       m_ptr;
  bit       stalled;

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic m_reset();
    for (int k = 0; k < 4; k++) begin
      m_full[k] = 0;
      m_word[k] = 0;
      m_cnt[k]  = 0;
    end
    m_last = 0;
    m_ptr  = 0;
  endtask

  function automatic int m_target();
    return bus.rr_mode ? m_ptr : int'(bus.in_sel);
  endfunction

  function automatic bit m_ready();
    int t = m_target();
    return !m_full[t] || bus.out_ready[t];
  endfunction

  task automatic m_clock(input bit rdy);
    int t = m_target();
    bit take = bus.in_valid && rdy;
    for (int k = 0; k < 4; k++)
      if (m_full[k] && bus.out_ready[k]) m_full[k] = 0;
    if (take) begin
      m_full[t] = 1;
      m_word[t] = int'(bus.in_data);
      m_cnt[t]  = (m_cnt[t] + 1) % 256;
      m_last    = t;
      if (bus.rr_mode) m_ptr = (m_ptr + 1) % 4;
    end
  endtask

  task automatic check_outs();
    logic [3:0]    ev;
    logic [4*W-1:0] ed;
    logic [4*C-1:0] ec;
    for (int k = 0; k < 4; k++) begin
      ev[k]          = m_full[k];
      ed[k*W +: W]   = W'(m_word[k]);
      ec[k*C +: C]   = C'(m_cnt[k]);
    end
    chk("out_valid", 64'(bus.out_valid), 64'(ev));
    chk("out_data",  64'(bus.out_data),  64'(ed));
    chk("out_count", 64'(bus.out_count), 64'(ec));
    chk("last_sel",  64'(bus.last_sel),  64'(m_last));
  endtask

  task automatic drive(input bit v, input int sel, input int d,
                       input bit rr, input logic [3:0] ordy);
    bus.in_valid  = v;
    bus.in_sel    = 2'(sel);
    bus.in_data   = W'(d);
    bus.rr_mode   = rr;
    bus.out_ready = ordy;
  endtask

  task automatic cycle();
    bit rdy;
    #1;
    rdy = m_ready();
    chk("in_ready", 64'(bus.in_ready), 64'(rdy));
    stalled = bus.in_valid && !rdy;
    @(posedge clk);
    m_clock(rdy);
    #1;
    check_outs();
  endtask

  initial begin
    m_reset();
    stalled = 0;
    drive(0, 0, 0, 0, 4'h0);
    #12;
    chk("rst_valid", 64'(bus.out_valid), 64'h0);
    chk("rst_count", 64'(bus.out_count), 64'h0);
    chk("rst_ready", 64'(bus.in_ready), 64'h1);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Directed routing, one word per channel.
    for (int k = 0; k < 4; k++) begin
      int d [4] = '{3, 5, 10, 15};
      drive(1, k, d[k], 0, 4'hF);
      cycle();
    end
    chk("last3", 64'(bus.last_sel), 64'd3);
    drive(0, 0, 0, 0, 4'hF);
    cycle();

    // Backpressure on channel 2.
    drive(1, 2, 4'hA, 0, 4'b1011);
    cycle();
    drive(1, 2, 4'hB, 0, 4'b1011);
    cycle();
    chk("bp_held", 64'(stalled), 64'd1);
    drive(1, 1, 4'hC, 0, 4'b1011);
    cycle();
    drive(1, 2, 4'hB, 0, 4'hF);
    cycle();
    drive(0, 0, 0, 0, 4'hF);
    cycle();

    // Round-robin order, then a stall on channel 1.
    for (int i = 1; i <= 8; i++) begin
      drive(1, 0, i, 1, 4'hF);
      cycle();
      chk("rr_order", 64'(bus.last_sel), 64'((i - 1) % 4));
    end
    for (int i = 9; i <= 14; i++) begin
      drive(1, 0, i, 1, 4'b1101);
      cycle();
    end
    for (int i = 0; i < 3; i++) begin
      drive(1, 0, 14, 1, 4'b1101);
      cycle();
      chk("rr_stall", 64'(stalled), 64'd1);
    end
    drive(1, 0, 14, 1, 4'hF);
    cycle();
    chk("rr_resume", 64'(bus.last_sel), 64'd1);

    // Mid-cycle async reset with channels 1 and 3 full.
    drive(1, 1, 7, 0, 4'h0);
    cycle();
    drive(1, 3, 9, 0, 4'h0);
    cycle();
    chk("pre_rst", 64'(bus.out_valid), 64'b1010);
    drive(0, 1, 0, 0, 4'h0);
    #2;
    rst = 1'b1;
    #1;
    m_reset();
    chk("arst_valid", 64'(bus.out_valid), 64'h0);
    chk("arst_count", 64'(bus.out_count), 64'h0);
    chk("arst_last",  64'(bus.last_sel),  64'h0);
    chk("arst_ready", 64'(bus.in_ready),  64'h1);
    #2;
    rst = 1'b0;

    // Counter wrap on channel 0.
    for (int i = 0; i < 256; i++) begin
      drive(1, 0, i, 0, 4'hF);
      cycle();
    end
    chk("wrap0", 64'(bus.out_count), 64'h0);

    // Drain and refill channel 3 back to back.
    for (int i = 0; i < 4; i++) begin
      drive(1, 3, 4 + i, 0, 4'hF);
      cycle();
      chk("pass3", 64'(bus.out_valid[3]), 64'd1);
    end

    // Random traffic; held inputs stay stable while stalled.
    for (int i = 0; i < 600; i++) begin
      logic [3:0] ordy = 4'($urandom);
      bit rr = ($urandom_range(0, 3) == 0) ? !bus.rr_mode : bus.rr_mode;
      if (stalled)
        drive(1, int'(bus.in_sel), int'(bus.in_data), rr, ordy);
      else
        drive($urandom_range(0, 1), $urandom_range(0, 3),
              $urandom_range(0, 15), rr, ordy);
      cycle();
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_err);
    $finish;
  end

endmodule
